// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with a memory-ready handshake.
// Define CONTROLE_EXC_EN to trap illegal opcodes into the EXC state instead of dropping them.
module controle_multiciclo #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int STATE_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic [1:0]          reg_dst,
    output logic                reg_write,
    output logic                write_pc4,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic [STATE_W-1:0]  state,
    output logic                exc
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MREAD  = 4'd3,
        S_MWB    = 4'd4,
        S_MWRITE = 4'd5,
        S_RTYPE  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
`ifdef CONTROLE_EXC_EN
        , S_EXC  = 4'd13
`endif
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] OP_SLTIU = OPCODE_W'(6'b001011);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(6'b001110);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'b001111);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(7);

    state_t state_q, state_d, state_n;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        state_q <= state_d;
    end

    assign state = state_q;

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_n       = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 2'd0;
        reg_write     = 1'b0;
        write_pc4     = 1'b0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        alu_op        = ALU_ADD;
        pc_source     = 2'd0;
        exc           = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_n   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_RTYPE:                 state_n = S_RTYPE;
                    OP_LW, OP_SW:             state_n = S_MADDR;
                    OP_BEQ, OP_BNE:           state_n = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                    OP_SLTI, OP_SLTIU, OP_LUI: state_n = S_IEXEC;
                    OP_J:                     state_n = S_JUMP;
                    OP_JAL:                   state_n = S_JAL;
                    default: begin
`ifdef CONTROLE_EXC_EN
                        state_n = S_EXC;
`endif
                    end
                endcase
            end
            S_MADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                state_n   = (opcode == OP_SW) ? S_MWRITE : S_MREAD;
            end
            S_MREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_n  = mem_ready ? S_MWB : S_MREAD;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_n   = mem_ready ? S_FETCH : S_MWRITE;
            end
            S_RTYPE: begin
                alu_src_a = 2'd1;
                alu_op    = ALU_FUNCT;
                state_n   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
            end
            S_BRANCH: begin
                alu_src_a     = 2'd1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                branch_ne     = opcode[0];
            end
            S_IEXEC: begin
                alu_src_a = (opcode == OP_LUI) ? 2'd2 : 2'd1;
                alu_src_b = (opcode == OP_LUI) ? 2'd3 : 2'd2;
                case (opcode)
                    OP_ANDI:  alu_op = ALU_AND;
                    OP_ORI:   alu_op = ALU_OR;
                    OP_XORI:  alu_op = ALU_XOR;
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    default:  alu_op = ALU_ADD;
                endcase
                state_n = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                reg_write = 1'b1;
                reg_dst   = 2'd2;
                write_pc4 = 1'b1;
            end
`ifdef CONTROLE_EXC_EN
            S_EXC: begin
                exc       = 1'b1;
                pc_write  = 1'b1;
                pc_source = 2'd3;
            end
`endif
            default: ;
        endcase

        // A reset cycle abandons the instruction: no architectural write may escape.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            exc           = 1'b0;
        end

        state_d = reset ? S_FETCH : state_n;
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: expected per-cycle control vectors are queued while
// stimulus is driven and compared against vectors captured at each falling edge.
module tb_controle_multiciclo;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       write_pc4;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       exc;
    } ctl_t;

    logic       clock, reset, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, write_pc4, exc;
    logic [1:0] reg_dst, alu_src_a, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    controle_multiciclo dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .write_pc4(write_pc4), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .state(state), .exc(exc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;
    ctl_t act;
    ctl_t exp_q[$];
    ctl_t act_q[$];

    always_comb begin
        act               = '0;
        act.state         = state;
        act.pc_write      = pc_write;
        act.pc_write_cond = pc_write_cond;
        act.branch_ne     = branch_ne;
        act.i_or_d        = i_or_d;
        act.mem_read      = mem_read;
        act.mem_write     = mem_write;
        act.ir_write      = ir_write;
        act.mem_to_reg    = mem_to_reg;
        act.reg_dst       = reg_dst;
        act.reg_write     = reg_write;
        act.write_pc4     = write_pc4;
        act.alu_src_a     = alu_src_a;
        act.alu_src_b     = alu_src_b;
        act.alu_op        = alu_op;
        act.pc_source     = pc_source;
        act.exc           = exc;
    end

    // Capture outputs mid-cycle, well away from the rising edge.
    always @(negedge clock) if (mon_en) act_q.push_back(act);

    // Expected control vector for each state, written from the state table.
    function automatic ctl_t v_base(input logic [3:0] s);
        ctl_t v = '0;
        v.state = s;
        return v;
    endfunction
    function automatic ctl_t v_fetch(input logic rdy);
        ctl_t v = v_base(4'd0);
        v.mem_read = 1'b1; v.alu_src_b = 2'd1; v.ir_write = rdy; v.pc_write = rdy;
        return v;
    endfunction
    function automatic ctl_t v_decode();
        ctl_t v = v_base(4'd1);
        v.alu_src_b = 2'd3;
        return v;
    endfunction
    function automatic ctl_t v_maddr();
        ctl_t v = v_base(4'd2);
        v.alu_src_a = 2'd1; v.alu_src_b = 2'd2;
        return v;
    endfunction
    function automatic ctl_t v_mread();
        ctl_t v = v_base(4'd3);
        v.mem_read = 1'b1; v.i_or_d = 1'b1;
        return v;
    endfunction
    function automatic ctl_t v_mwb();
        ctl_t v = v_base(4'd4);
        v.reg_write = 1'b1; v.mem_to_reg = 1'b1;
        return v;
    endfunction
    function automatic ctl_t v_mwrite();
        ctl_t v = v_base(4'd5);
        v.mem_write = 1'b1; v.i_or_d = 1'b1;
        return v;
    endfunction
    function automatic ctl_t v_rtype();
        ctl_t v = v_base(4'd6);
        v.alu_src_a = 2'd1; v.alu_op = 3'd2;
        return v;
    endfunction
    function automatic ctl_t v_rwb();
        ctl_t v = v_base(4'd7);
        v.reg_write = 1'b1; v.reg_dst = 2'd1;
        return v;
    endfunction
    function automatic ctl_t v_branch(input logic ne);
        ctl_t v = v_base(4'd8);
        v.alu_src_a = 2'd1; v.alu_op = 3'd1; v.pc_write_cond = 1'b1;
        v.pc_source = 2'd1; v.branch_ne = ne;
        return v;
    endfunction
    function automatic ctl_t v_iexec(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op);
        ctl_t v = v_base(4'd9);
        v.alu_src_a = a; v.alu_src_b = b; v.alu_op = op;
        return v;
    endfunction
    function automatic ctl_t v_iwb();
        ctl_t v = v_base(4'd10);
        v.reg_write = 1'b1;
        return v;
    endfunction
    function automatic ctl_t v_jump();
        ctl_t v = v_base(4'd11);
        v.pc_write = 1'b1; v.pc_source = 2'd2;
        return v;
    endfunction
    function automatic ctl_t v_jal();
        ctl_t v = v_base(4'd12);
        v.pc_write = 1'b1; v.pc_source = 2'd2; v.reg_write = 1'b1;
        v.reg_dst = 2'd2; v.write_pc4 = 1'b1;
        return v;
    endfunction
    function automatic ctl_t v_exc();
        ctl_t v = v_base(4'd13);
        v.exc = 1'b1; v.pc_write = 1'b1; v.pc_source = 2'd3;
        return v;
    endfunction

    // One clock of stimulus; entered and left at posedge+1.
    task automatic drive(input logic rdy, input ctl_t e);
        mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ctl_t e, a;
        mon_en = 1'b1;
        drive(1'b1, v_fetch(1'b0));      // reset held: FETCH outputs, write strobes gated
        reset = 1'b0; opcode = 6'b100011;
        drive(1'b1, v_fetch(1'b1));
        drive(1'b1, v_decode());
        drive(1'b1, v_maddr());
        drive(1'b0, v_mread());
        reset = 1'b1;                    // three reset cycles mid-LW
        drive(1'b1, v_mread());
        drive(1'b1, v_fetch(1'b0));
        drive(1'b1, v_fetch(1'b0));
        reset = 1'b0;
        drive(1'b0, v_fetch(1'b0));
        mon_en = 1'b0;
        n_checks++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_len: got %0d samples, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && act_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: state %0d vec %h, expected state %0d vec %h", i, a.state, a, e.state, e);
            end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_lw_wait();
        ctl_t e, a;
        int ir_cnt = 0;
        opcode = 6'b100011;
        mon_en = 1'b1;
        drive(1'b0, v_fetch(1'b0));
        drive(1'b0, v_fetch(1'b0));
        drive(1'b1, v_fetch(1'b1));
        drive(1'b1, v_decode());
        drive(1'b1, v_maddr());
        drive(1'b0, v_mread());
        drive(1'b1, v_mread());
        drive(1'b1, v_mwb());
        drive(1'b0, v_fetch(1'b0));      // ninth cycle is the next FETCH
        mon_en = 1'b0;
        n_checks++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL lw_len: got %0d samples, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && act_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (i < 8) ir_cnt += int'(a.ir_write);
            if (a !== e) begin
                n_fail++;
                $display("FAIL lw[%0d]: state %0d vec %h, expected state %0d vec %h", i, a.state, a, e.state, e);
            end
        end
        n_checks++;
        if (ir_cnt !== 1) begin
            n_fail++;
            $display("FAIL lw_ir_write_count: got %0d, expected 1", ir_cnt);
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_sw_branch_rtype();
        ctl_t e, a;
        mon_en = 1'b1;
        opcode = 6'b101011;              // SW with one wait cycle in MWRITE
        drive(1'b1, v_fetch(1'b1));
        drive(1'b0, v_decode());
        drive(1'b1, v_maddr());
        drive(1'b0, v_mwrite());
        drive(1'b1, v_mwrite());
        opcode = 6'b000101;              // BNE
        drive(1'b1, v_fetch(1'b1));
        drive(1'b1, v_decode());
        drive(1'b1, v_branch(1'b1));
        opcode = 6'b000100;              // BEQ
        drive(1'b1, v_fetch(1'b1));
        drive(1'b1, v_decode());
        drive(1'b1, v_branch(1'b0));
        opcode = 6'b000000;              // R-type
        drive(1'b1, v_fetch(1'b1));
        drive(1'b1, v_decode());
        drive(1'b1, v_rtype());
        drive(1'b1, v_rwb());
        drive(1'b0, v_fetch(1'b0));
        mon_en = 1'b0;
        n_checks++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL sbr_len: got %0d samples, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && act_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL sw_branch_rtype[%0d]: state %0d vec %h, expected state %0d vec %h", i, a.state, a, e.state, e);
            end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_imm();
        ctl_t e, a;
        logic [5:0] ops  [7] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001011, 6'b001010, 6'b001111};
        logic [2:0] aops [7] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6, 3'd0};
        mon_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            opcode = ops[k];
            drive(1'b1, v_fetch(1'b1));
            drive(1'b1, v_decode());
            if (k == 6) drive(1'b1, v_iexec(2'd2, 2'd3, aops[k]));
            else        drive(1'b1, v_iexec(2'd1, 2'd2, aops[k]));
            drive(1'b1, v_iwb());
        end
        mon_en = 1'b0;
        n_checks++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL imm_len: got %0d samples, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && act_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL imm[%0d]: state %0d vec %h, expected state %0d vec %h", i, a.state, a, e.state, e);
            end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_jump_illegal();
        ctl_t e, a;
        mon_en = 1'b1;
        opcode = 6'b000010;              // J
        drive(1'b1, v_fetch(1'b1));
        drive(1'b1, v_decode());
        drive(1'b1, v_jump());
        opcode = 6'b000011;              // JAL
        drive(1'b1, v_fetch(1'b1));
        drive(1'b1, v_decode());
        drive(1'b1, v_jal());
        opcode = 6'b111111;              // illegal
        drive(1'b1, v_fetch(1'b1));
        drive(1'b1, v_decode());
`ifdef CONTROLE_EXC_EN
        drive(1'b1, v_exc());
`endif
        drive(1'b0, v_fetch(1'b0));
        drive(1'b0, v_fetch(1'b0));
        mon_en = 1'b0;
        n_checks++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL jmp_len: got %0d samples, expected %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && act_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL jump_illegal[%0d]: state %0d vec %h, expected state %0d vec %h", i, a.state, a, e.state, e);
            end
        end
        exp_q.delete(); act_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        test_reset();
        test_lw_wait();
        test_sw_branch_rtype();
        test_imm();
        test_jump_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- Moore/Mealy FSM sequencing each instruction over 3–5 states: FETCH, DECODE, EXEC, MEM, WB.
- Sits between the instruction register (opcode) and the shared-memory/ALU datapath, and waits on a memory ready handshake.
- Gives distinct ALU operations for ANDI/ORI/XORI/SLTI/SLTIU/LUI, replacing the shared ALUOp codes.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 3, alu_op width; must be ≥3.
- STATE_W, 4, state register width.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  OPCODE_W  IR[31:26], stable from DECODE onwards
- mem_ready  input  1  memory completed the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if the branch condition holds
- branch_ne  output  1  0 = take on zero (BEQ), 1 = take on not-zero (BNE)
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  output  1
- mem_write  output  1
- ir_write  output  1
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR
- reg_dst  output  2  0 = rt, 1 = rd, 2 = $31
- reg_write  output  1
- write_pc4  output  1  write-back data = PC (already PC+4)
- alu_src_a  output  2  0 = PC, 1 = A, 2 = zero
- alu_src_b  output  2  0 = B, 1 = 4, 2 = sign-ext imm, 3 = imm<<16 (LUI), or sign-ext imm<<2 in DECODE
- alu_op  output  ALUOP_W  0 add, 1 sub, 2 funct, 3 and, 4 or, 5 xor, 6 slt, 7 sltu
- pc_source  output  2  0 = ALU, 1 = ALUOut, 2 = jump target, 3 = exception vector
- state  output  STATE_W  current state, for debug
- exc  output  1  illegal-opcode pulse

Behaviour:
- Reset: synchronous, active-high; dominates everything. Next state = FETCH.
- Outputs during reset and idle: all outputs 0 and alu_op = add, except those of the current state.
- Mid-instruction reset: abandons the instruction; no write strobes are asserted in the reset cycle.
- Outputs are decoded combinationally from the state register; the only Mealy terms are the mem_ready qualifications below.
- Illegal opcode (without EXC_EN): any opcode outside the decoded set goes DECODE → FETCH; no writes, no PC change.
- States and transitions:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_source=0.
    - ir_write and pc_write = mem_ready.
    - Stay while !mem_ready; → DECODE when mem_ready.
  - DECODE(1): alu_src_a=0, alu_src_b=3 (branch offset), alu_op=add.
    - → RTYPE on 000000; → MADDR on LW/SW; → BRANCH on BEQ/BNE.
    - → IEXEC on ADDI/ANDI/ORI/XORI/SLTI/SLTIU/LUI.
    - → JUMP on J; → JAL on JAL.
  - MADDR(2): alu_src_a=1, alu_src_b=2, add. → MREAD (LW) or MWRITE (SW).
  - MREAD(3): mem_read=1, i_or_d=1. Hold until mem_ready; → MWB.
  - MWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. → FETCH.
  - MWRITE(5): mem_write=1, i_or_d=1. Hold until mem_ready; → FETCH. mem_write stays high while held.
  - RTYPE(6): alu_src_a=1, alu_src_b=0, alu_op=funct. → RWB.
  - RWB(7): reg_write=1, reg_dst=1. → FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=0, sub, pc_write_cond=1, pc_source=1, branch_ne=opcode[0]. → FETCH.
  - IEXEC(9): alu_src_b=2 (3 for LUI).
    - alu_src_a=1 (2 for LUI).
    - alu_op: ADDI add, ANDI and, ORI or, XORI xor, SLTI slt, SLTIU sltu, LUI add.
    - → IWB.
  - IWB(10): reg_write=1, reg_dst=0. → FETCH.
  - JUMP(11): pc_write=1, pc_source=2. → FETCH.
  - JAL(12): pc_write=1, pc_source=2, reg_write=1, reg_dst=2, write_pc4=1. → FETCH.
  - EXC(13): see Optional Feature.
- CPI per class: R/I = 4, LW = 5, SW = 4, BEQ/BNE/J/JAL = 3, each plus memory wait cycles.
- Memory handshake: mem_read/mem_write are held constant until the mem_ready cycle.
  - mem_ready outside FETCH/MREAD/MWRITE is ignored.
- Unused state encodings (14, 15) → FETCH next cycle, outputs all 0.

Optional Feature:
- Macro: CONTROLE_EXC_EN.
- Defined: an illegal opcode goes DECODE → EXC.
  - EXC: exc=1, pc_write=1, pc_source=3, all other strobes 0. → FETCH.
  - exc is a one-cycle pulse.
- Undefined: the EXC state is absent, exc is tied 0, and an illegal opcode goes DECODE → FETCH.

Test Plan:
- Reset held 3 cycles mid-LW (state=MREAD) → state=0, mem_read=1 in the first post-reset cycle, and no reg_write.
- LW with mem_ready low for 2 cycles in FETCH and 1 in MREAD → 8 cycles total; ir_write high exactly once; reg_write, mem_to_reg high in MWB.
- BNE (000101) → BRANCH with pc_write_cond=1, branch_ne=1, alu_op=1; BEQ gives branch_ne=0; both return to FETCH after 3 cycles.
- ANDI/ORI/XORI/SLTI/SLTIU in IEXEC → alu_op = 3/4/5/6/7; LUI → alu_src_a=2, alu_src_b=3, alu_op=0.
- JAL (000011) → JAL state: reg_dst=2, write_pc4=1, reg_write=1, pc_source=2, pc_write=1.
- Opcode 111111 → with CONTROLE_EXC_EN: exc pulse 1 cycle, pc_source=3. Without: DECODE → FETCH, no strobes.
